vec_shared_mem: RTL and testbench
=================================

Name: vec_shared_mem

Overview:
- Parametrised shared word memory serving NUM_PORTS PicoRV32-native request ports, e.g. port 0 = CPU, port 1 = vector coprocessor load/store unit.
- Supersedes the two independent single-cycle memory processes that both access one array: adds arbitration, configurable latency, byte strobes per port and an out-of-range error response.
- Sits between core/coprocessor memory interfaces and the backing array in system benches and FPGA builds.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..8).
- DEPTH_WORDS, 256, 32-bit words in the array; byte address range is 0..DEPTH_WORDS*4-1.
- LATENCY, 1, cycles from grant edge to the ready pulse (1..15).
- INIT_FILE, "", hex file loaded with $readmemh when non-empty; otherwise the array is uninitialised.

Ports:
- clk, in, 1, clock; all logic is on the rising edge.
- resetn, in, 1, asynchronous active-low reset.
- port_valid, in, NUM_PORTS, request valid, one bit per port.
- port_addr, in, NUM_PORTS*32, byte address; port p occupies [32p+31:32p].
- port_wdata, in, NUM_PORTS*32, write data.
- port_wstrb, in, NUM_PORTS*4, byte write strobes; 0 = read.
- port_ready, out, NUM_PORTS, one-cycle completion pulse per port.
- port_rdata, out, NUM_PORTS*32, read data; valid while the matching ready is high.
- port_err, out, NUM_PORTS, pulses with ready when the address is out of range.
- busy, out, 1, high in every state except IDLE.

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE; port_ready, port_err, busy and all port_rdata go to 0.
  - Round-robin pointer goes to 0 (port 0 has highest priority first).
  - Array contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - On an edge with any port_valid high, grant one port.
  - At the grant edge, latch the address, wdata, wstrb and port index.
  - If LATENCY==1, go to RESP; otherwise go to WAIT with a counter of LATENCY-1.
- WAIT: decrement the counter each cycle; when it reaches 0, go to RESP.
- Array access takes place on the edge that enters RESP.
  - Word index = addr[31:2]; addr[1:0] is ignored.
  - port_rdata receives the pre-write word, i.e. read-before-write.
  - Bytes with wstrb[i] set are written.
- RESP:
  - port_ready[granted] is high for exactly one cycle; all other ready bits stay 0.
  - Next state is always IDLE, and no grant is made during RESP.
  - A requester drops valid at the edge where it samples ready, so it cannot be granted twice for one request.
- Timing:
  - Ready goes high LATENCY cycles after the grant edge; LATENCY=1 matches the legacy single-cycle behaviour.
  - Peak throughput is one access per 2 cycles when LATENCY=1.
- Out of range (addr >= DEPTH_WORDS*4):
  - No array write takes place.
  - rdata = 0; port_err[granted] pulses together with ready.
  - The transaction never hangs.
- Arbitration (default, round-robin):
  - Search starts at last_grant+1 mod NUM_PORTS; the first valid port wins.
  - last_grant updates at the grant edge.
- Simultaneous requests: the losing port keeps valid asserted and is served on a later IDLE cycle; no request is dropped.
- Requests deasserted before grant: this is a protocol violation and its effect is unspecified.
- port_rdata of non-granted ports holds its last value.
- Reset mid-operation:
  - In WAIT, the transaction is aborted and no write is committed.
  - In RESP, the write is already committed; ready drops immediately.
- The busy output equals (state != IDLE).

Optional Feature:
- Macro: VEC_SHARED_MEM_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest-index valid port always wins, so the CPU on port 0 preempts the vector unit. The last_grant register is removed.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Single read, LATENCY=1: memory[100]=0x2; port 1 reads addr 400.
  - Required: port_ready[1] high in the cycle after the grant edge, rdata=0x00000002, port_ready[0]=0.
- Byte write then read: port 1 writes addr 800, wdata 0xAABBCCDD, wstrb 4'b0101, then reads addr 800; word was 0.
  - Required: the read returns 0x00BB00DD.
  - Required: the write's own rdata is the old value 0x00000000.
- Contention, round-robin: both ports assert valid continuously for 4 requests each.
  - Required: grants alternate 0,1,0,1,...
  - Required: each ready is a single cycle, with at least one idle cycle between readies.
  - Under VEC_SHARED_MEM_FIXED_PRIO_EN, all port-0 requests complete first.
- LATENCY=3: read addr 4.
  - Required: ready asserted exactly 3 cycles after the grant edge.
  - Required: busy is high from the grant edge until ready falls.
- Out of range, DEPTH_WORDS=256: read addr 1024 and write addr 2000.
  - Required: each returns ready together with port_err, rdata=0.
  - Required: the array is unchanged and the bench does not hang.
- Reset mid-WAIT, LATENCY=4: write to addr 8, then drop resetn during WAIT.
  - Required: outputs go to 0 asynchronously and memory[2] is unchanged.
  - Required: after release, port 0 has priority.

Source files
------------

// File: rtl/vec_shared_mem.sv
// vec_shared_mem: shared 32-bit word memory for NUM_PORTS PicoRV32-native
// request ports (e.g. port 0 = CPU, port 1 = vector load/store unit).
// One request is served at a time. The array access happens on the edge
// that enters RESP, and the matching ready pulse follows LATENCY cycles
// after the grant edge. Reads return the pre-write word. Out-of-range
// addresses complete with port_err and rdata = 0 and leave the array alone.
//
// Optional build macro:
//   VEC_SHARED_MEM_FIXED_PRIO_EN - lowest-index valid port always wins.
//                                  Without it, arbitration is round-robin.
//
// Ports:
//   clk        - clock, rising edge
//   resetn     - asynchronous active-low reset
//   port_valid - [NUM_PORTS]    request valid per port
//   port_addr  - [NUM_PORTS*32] byte address, port p at [32p+31:32p]
//   port_wdata - [NUM_PORTS*32] write data
//   port_wstrb - [NUM_PORTS*4]  byte write strobes, 0 = read
//   port_ready - [NUM_PORTS]    one-cycle completion pulse
//   port_rdata - [NUM_PORTS*32] read data, held between completions
//   port_err   - [NUM_PORTS]    out-of-range flag, pulses with ready
//   busy       - high whenever the FSM is not IDLE
module vec_shared_mem #(
  parameter int NUM_PORTS   = 2,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_PORTS-1:0]    port_valid,
  input  logic [NUM_PORTS*32-1:0] port_addr,
  input  logic [NUM_PORTS*32-1:0] port_wdata,
  input  logic [NUM_PORTS*4-1:0]  port_wstrb,
  output logic [NUM_PORTS-1:0]    port_ready,
  output logic [NUM_PORTS*32-1:0] port_rdata,
  output logic [NUM_PORTS-1:0]    port_err,
  output logic                    busy
);

  localparam int          IDXW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;

  logic [31:0]     req_addr  [NUM_PORTS];
  logic [31:0]     req_wdata [NUM_PORTS];
  logic [3:0]      req_wstrb [NUM_PORTS];
  logic [31:0]     rdata_q   [NUM_PORTS];

  logic            gnt_found;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] cand;
  logic            grant;

  logic [IDXW-1:0] g_idx;
  logic [31:0]     g_addr;
  logic [31:0]     g_wdata;
  logic [3:0]      g_wstrb;

  logic [IDXW-1:0] acc_idx;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_wstrb;
  logic            acc_en;
  logic            acc_in_range;
  logic [AW-1:0]   acc_word;
  logic            mem_we;

  logic [31:0]     mem [DEPTH_WORDS];

  // Flattened buses viewed as per-port arrays.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      req_addr[p]  = port_addr[p*32 +: 32];
      req_wdata[p] = port_wdata[p*32 +: 32];
      req_wstrb[p] = port_wstrb[p*4 +: 4];
    end
  end

  always_comb begin
    port_rdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      port_rdata[p*32 +: 32] = rdata_q[p];
    end
  end

`ifdef VEC_SHARED_MEM_FIXED_PRIO_EN
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IDXW'(i);
      if (!gnt_found && port_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
`else
  // rr_ptr holds last_grant+1 mod NUM_PORTS, so resetting it to 0 gives
  // port 0 first priority after reset.
  logic [IDXW-1:0] rr_ptr;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IDXW'((32'(rr_ptr) + i) % 32'(NUM_PORTS));
      if (!gnt_found && port_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (gnt_idx == IDXW'(NUM_PORTS - 1)) ? '0 : gnt_idx + IDXW'(1);
    end
  end
`endif

  assign grant = (state == S_IDLE) && gnt_found;
  assign busy  = (state != S_IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (gnt_found) begin
          if (LATENCY == 1) begin
            state_n = S_RESP;
          end else begin
            state_n = S_WAIT;
            cnt_n   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = S_RESP;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // With LATENCY==1 the access edge is the grant edge itself, so the
  // access takes the live request instead of the latched copy.
  always_comb begin
    if (state == S_IDLE) begin
      acc_idx   = gnt_idx;
      acc_addr  = req_addr[gnt_idx];
      acc_wdata = req_wdata[gnt_idx];
      acc_wstrb = req_wstrb[gnt_idx];
    end else begin
      acc_idx   = g_idx;
      acc_addr  = g_addr;
      acc_wdata = g_wdata;
      acc_wstrb = g_wstrb;
    end
    acc_en       = (state_n == S_RESP);
    acc_in_range = (acc_addr < ADDR_LIMIT);
    acc_word     = acc_addr[AW+1:2];
    // Gated by resetn so no write lands while reset is held.
    mem_we       = acc_en && acc_in_range && resetn;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      g_idx      <= '0;
      g_addr     <= '0;
      g_wdata    <= '0;
      g_wstrb    <= '0;
      port_ready <= '0;
      port_err   <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        rdata_q[p] <= '0;
      end
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      port_ready <= '0;
      port_err   <= '0;
      if (grant) begin
        g_idx   <= gnt_idx;
        g_addr  <= req_addr[gnt_idx];
        g_wdata <= req_wdata[gnt_idx];
        g_wstrb <= req_wstrb[gnt_idx];
      end
      if (acc_en) begin
        port_ready[acc_idx] <= 1'b1;
        port_err[acc_idx]   <= !acc_in_range;
        rdata_q[acc_idx]    <= acc_in_range ? mem[acc_word] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) begin
          mem[acc_word][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_shared_mem.sv
module tb_vec_shared_mem;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  valid [3];
    logic [63:0] addr  [3];
    logic [63:0] wdata [3];
    logic [7:0]  wstrb [3];
    logic [1:0]  ready [3];
    logic [63:0] rdata [3];
    logic [1:0]  err   [3];
    logic        busy  [3];

    logic [31:0] mdl [3][256];
    int          rr_next [3];
    int          n_checks;
    int          n_pass;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            vec_shared_mem #(
                .NUM_PORTS  (2),
                .DEPTH_WORDS(256),
                .LATENCY    (g == 0 ? 1 : (g == 1 ? 3 : 4)),
                .INIT_FILE  ("")
            ) u_dut (
                .clk       (clk),
                .resetn    (resetn),
                .port_valid(valid[g]),
                .port_addr (addr[g]),
                .port_wdata(wdata[g]),
                .port_wstrb(wstrb[g]),
                .port_ready(ready[g]),
                .port_rdata(rdata[g]),
                .port_err  (err[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic wait_idle(input int d);
        for (int c = 0; c < 40 && busy[d]; c++) begin
            @(posedge clk); #1;
        end
    endtask

    // Drives one request on port p of instance d and waits for its ready.
    task automatic xact(input int d, input int p, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] rd, output logic er,
                        output logic [1:0] rv, output int cyc, output logic ok);
        wait_idle(d);
        addr[d][p*32 +: 32]  = a;
        wdata[d][p*32 +: 32] = wd;
        wstrb[d][p*4 +: 4]   = ws;
        valid[d][p]          = 1'b1;
        ok = 1'b0; cyc = 0; rd = '0; er = 1'b0; rv = '0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (ready[d][p]) begin
                ok = 1'b1;
                rd = rdata[d][p*32 +: 32];
                er = err[d][p];
                rv = ready[d];
            end
        end
        valid[d][p] = 1'b0;
        if (ok) begin
            rr_next[d] = (p + 1) % 2;
            if (a < 32'd1024) mdl[d][a[9:2]] = merge(mdl[d][a[9:2]], wd, ws);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (ready[d] !== 2'b00) $display("FAIL reset_ready d=%0d got=%b exp=00", d, ready[d]);
            else n_pass++;
            n_checks++;
            if (err[d] !== 2'b00) $display("FAIL reset_err d=%0d got=%b exp=00", d, err[d]);
            else n_pass++;
            n_checks++;
            if (busy[d] !== 1'b0) $display("FAIL reset_busy d=%0d got=%b exp=0", d, busy[d]);
            else n_pass++;
            n_checks++;
            if (rdata[d] !== 64'd0) $display("FAIL reset_rdata d=%0d got=%h exp=0", d, rdata[d]);
            else n_pass++;
            rr_next[d] = 0;
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic fill_memory;
        logic [31:0] rd; logic er; logic [1:0] rv; int cyc; logic ok; logic all_ok;
        all_ok = 1'b1;
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 256; w++) begin
                xact(d, w % 2, 32'(w * 4), $urandom, 4'hf, rd, er, rv, cyc, ok);
                if (!ok) all_ok = 1'b0;
            end
        end
        n_checks++;
        if (all_ok !== 1'b1) $display("FAIL fill_timeout got=%b exp=1", all_ok);
        else n_pass++;
    endtask

    task automatic test_single_read;
        logic [31:0] rd; logic er; logic [1:0] rv; int cyc; logic ok;
        xact(0, 0, 32'd400, 32'h2, 4'hf, rd, er, rv, cyc, ok);
        xact(0, 1, 32'd400, 32'h0, 4'h0, rd, er, rv, cyc, ok);
        n_checks++;
        if (!(ok && cyc == 1)) $display("FAIL single_read_latency got ok=%b cyc=%0d exp cyc=1", ok, cyc);
        else n_pass++;
        n_checks++;
        if (rd !== 32'h00000002) $display("FAIL single_read_rdata got=%h exp=00000002", rd);
        else n_pass++;
        n_checks++;
        if (rv[0] !== 1'b0) $display("FAIL single_read_other_ready got=%b exp=0", rv[0]);
        else n_pass++;
        n_checks++;
        if (er !== 1'b0) $display("FAIL single_read_err got=%b exp=0", er);
        else n_pass++;
    endtask

    task automatic test_byte_write;
        logic [31:0] rd; logic er; logic [1:0] rv; int cyc; logic ok;
        xact(0, 1, 32'd800, 32'h0, 4'hf, rd, er, rv, cyc, ok);
        xact(0, 1, 32'd800, 32'hAABBCCDD, 4'b0101, rd, er, rv, cyc, ok);
        n_checks++;
        if (!ok || rd !== 32'h0) $display("FAIL byte_write_old_rdata got=%h ok=%b exp=00000000", rd, ok);
        else n_pass++;
        xact(0, 1, 32'd800, 32'h0, 4'h0, rd, er, rv, cyc, ok);
        n_checks++;
        if (!ok || rd !== 32'h00BB00DD) $display("FAIL byte_write_readback got=%h ok=%b exp=00bb00dd", rd, ok);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] rd, a, expv; logic er; logic [1:0] rv; int cyc, d, p; logic ok;
        for (int it = 0; it < 30; it++) begin
            d = $urandom_range(0, 2);
            p = $urandom_range(0, 1);
            a = 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
            expv = mdl[d][a[9:2]];
            xact(d, p, a, $urandom, 4'($urandom_range(0, 15)), rd, er, rv, cyc, ok);
            n_checks++;
            if (!ok || cyc != lat_of(d)) $display("FAIL random_latency d=%0d got=%0d exp=%0d ok=%b", d, cyc, lat_of(d), ok);
            else n_pass++;
            n_checks++;
            if (rd !== expv) $display("FAIL random_rdata d=%0d addr=%h got=%h exp=%h", d, a, rd, expv);
            else n_pass++;
            n_checks++;
            if (er !== 1'b0) $display("FAIL random_err d=%0d got=%b exp=0", d, er);
            else n_pass++;
        end
    endtask

    task automatic test_contention(input int d, input int nreq);
        int rem [2];
        logic [31:0] caddr [2];
        logic [31:0] cwd [2];
        logic [3:0] cws [2];
        logic prev;
        int cycles, exp_p, got_p;
        logic [1:0] exp_vec;
        logic [31:0] exp_rd;
        wait_idle(d);
        for (int q = 0; q < 2; q++) begin
            rem[q]   = nreq;
            caddr[q] = 32'($urandom_range(0, 255) * 4);
            cwd[q]   = $urandom;
            cws[q]   = 4'($urandom_range(0, 15));
            addr[d][q*32 +: 32]  = caddr[q];
            wdata[d][q*32 +: 32] = cwd[q];
            wstrb[d][q*4 +: 4]   = cws[q];
        end
        valid[d] = 2'b11;
        prev = 1'b0;
        cycles = 0;
        while ((rem[0] > 0 || rem[1] > 0) && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
            if (ready[d] != 2'b00) begin
`ifdef VEC_SHARED_MEM_FIXED_PRIO_EN
                exp_p = (rem[0] > 0) ? 0 : 1;
`else
                exp_p = (rem[rr_next[d]] > 0) ? rr_next[d] : 1 - rr_next[d];
`endif
                exp_vec = (exp_p == 0) ? 2'b01 : 2'b10;
                got_p = ready[d][0] ? 0 : 1;
                n_checks++;
                if (ready[d] !== exp_vec) $display("FAIL contention_order d=%0d got=%b exp=%b", d, ready[d], exp_vec);
                else n_pass++;
                n_checks++;
                if (prev) $display("FAIL contention_gap d=%0d got=back-to-back ready exp=idle cycle between", d);
                else n_pass++;
                exp_rd = mdl[d][caddr[got_p][9:2]];
                n_checks++;
                if (rdata[d][got_p*32 +: 32] !== exp_rd)
                    $display("FAIL contention_rdata d=%0d port=%0d got=%h exp=%h", d, got_p, rdata[d][got_p*32 +: 32], exp_rd);
                else n_pass++;
                mdl[d][caddr[got_p][9:2]] = merge(exp_rd, cwd[got_p], cws[got_p]);
                rr_next[d] = (got_p + 1) % 2;
                rem[got_p]--;
                if (rem[got_p] > 0) begin
                    caddr[got_p] = 32'($urandom_range(0, 255) * 4);
                    cwd[got_p]   = $urandom;
                    cws[got_p]   = 4'($urandom_range(0, 15));
                    addr[d][got_p*32 +: 32]  = caddr[got_p];
                    wdata[d][got_p*32 +: 32] = cwd[got_p];
                    wstrb[d][got_p*4 +: 4]   = cws[got_p];
                end else begin
                    valid[d][got_p] = 1'b0;
                end
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
        valid[d] = 2'b00;
        n_checks++;
        if (rem[0] != 0 || rem[1] != 0) $display("FAIL contention_timeout d=%0d got rem=%0d/%0d exp=0/0", d, rem[0], rem[1]);
        else n_pass++;
    endtask

    task automatic test_latency;
        logic [7:0] bmask;
        int rdy_at;
        logic [31:0] rd, expv;
        wait_idle(1);
        expv = mdl[1][1];
        addr[1][31:0] = 32'd4;
        wstrb[1][3:0] = 4'h0;
        valid[1][0]   = 1'b1;
        bmask = '0; rdy_at = 0; rd = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            bmask[c-1] = busy[1];
            if (ready[1][0] && rdy_at == 0) begin
                rdy_at = c;
                rd = rdata[1][31:0];
                valid[1][0] = 1'b0;
            end
        end
        valid[1][0] = 1'b0;
        rr_next[1] = 1;
        n_checks++;
        if (rdy_at != 3) $display("FAIL latency3_ready_cycle got=%0d exp=3", rdy_at);
        else n_pass++;
        n_checks++;
        if (rd !== expv) $display("FAIL latency3_rdata got=%h exp=%h", rd, expv);
        else n_pass++;
        n_checks++;
        if (bmask !== 8'b0000_0111) $display("FAIL latency3_busy got=%b exp=00000111", bmask);
        else n_pass++;
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd, exp0, exp244; logic er; logic [1:0] rv; int cyc; logic ok;
        exp0   = mdl[0][0];
        exp244 = mdl[0][244];
        xact(0, 1, 32'd1024, 32'h0, 4'h0, rd, er, rv, cyc, ok);
        n_checks++;
        if (!ok || er !== 1'b1) $display("FAIL oor_read_err got ok=%b err=%b exp=1/1", ok, er);
        else n_pass++;
        n_checks++;
        if (rd !== 32'h0) $display("FAIL oor_read_rdata got=%h exp=0", rd);
        else n_pass++;
        xact(0, 0, 32'd2000, 32'hDEADBEEF, 4'hf, rd, er, rv, cyc, ok);
        n_checks++;
        if (!ok || er !== 1'b1) $display("FAIL oor_write_err got ok=%b err=%b exp=1/1", ok, er);
        else n_pass++;
        n_checks++;
        if (rd !== 32'h0) $display("FAIL oor_write_rdata got=%h exp=0", rd);
        else n_pass++;
        xact(0, 0, 32'd0, 32'h0, 4'h0, rd, er, rv, cyc, ok);
        n_checks++;
        if (rd !== exp0 || er !== 1'b0) $display("FAIL oor_word0_unchanged got=%h err=%b exp=%h", rd, er, exp0);
        else n_pass++;
        xact(0, 1, 32'd976, 32'h0, 4'h0, rd, er, rv, cyc, ok);
        n_checks++;
        if (rd !== exp244 || er !== 1'b0) $display("FAIL oor_word244_unchanged got=%h err=%b exp=%h", rd, er, exp244);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd, expv; logic er; logic [1:0] rv; int cyc; logic ok;
        wait_idle(2);
        expv = mdl[2][2];
        addr[2][31:0]  = 32'd8;
        wdata[2][31:0] = ~expv;
        wstrb[2][3:0]  = 4'hf;
        valid[2][0]    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (busy[2] !== 1'b1) $display("FAIL midwait_busy got=%b exp=1", busy[2]);
        else n_pass++;
        #2;
        resetn = 1'b0;
        valid[2] = 2'b00;
        #1;
        n_checks++;
        if (busy[2] !== 1'b0 || ready[2] !== 2'b00 || err[2] !== 2'b00)
            $display("FAIL midwait_async_ctrl got busy=%b ready=%b err=%b exp=0/00/00", busy[2], ready[2], err[2]);
        else n_pass++;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (rdata[d] !== 64'd0) $display("FAIL midwait_async_rdata d=%0d got=%h exp=0", d, rdata[d]);
            else n_pass++;
            rr_next[d] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        test_contention(2, 1);
        xact(2, 1, 32'd8, 32'h0, 4'h0, rd, er, rv, cyc, ok);
        n_checks++;
        if (!ok || rd !== expv) $display("FAIL midwait_no_write got=%h ok=%b exp=%h", rd, ok, expv);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int d = 0; d < 3; d++) begin
            valid[d] = '0;
            addr[d]  = '0;
            wdata[d] = '0;
            wstrb[d] = '0;
        end
        test_reset;
        fill_memory;
        test_single_read;
        test_byte_write;
        test_contention(0, 4);
        test_contention(1, 4);
        test_latency;
        test_out_of_range;
        test_random;
        test_reset_mid_wait;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
